// File: rtl/loader_pkg.sv
// Shared types and constants for the wishbone byte-stream loader.
// Optional readback verification is enabled with WB_LOADER_READBACK_EN.
package loader_pkg;

  localparam int WB_ADDR_W      = 32;
  localparam int WB_DATA_W      = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int TIMEOUT_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    FLUSH,
    DONE
`ifdef WB_LOADER_READBACK_EN
    ,
    VERIFY
`endif
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian words.
// Tracks the byte index and zero-fills unused lanes on flush.
module byte_packer
  import loader_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic                 flush_i,
  input  logic                 accept_i,
  input  logic [7:0]           byte_i,
  output logic [WB_DATA_W-1:0] word_o,
  output logic [2:0]           idx_o,
  output logic                 word_full_o
);

  logic [WB_DATA_W-1:0] word_q, word_d;
  logic [2:0]           idx_q, idx_d;

  // Lane steering, clear and zero-fill of unfilled upper lanes
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (flush_i) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (3'(b) >= idx_q) word_d[b*8 +: 8] = '0;
      end
    end else if (accept_i && idx_q < 3'(BYTES_PER_WORD)) begin
      word_d[idx_q[1:0]*8 +: 8] = byte_i;
      idx_d = idx_q + 3'd1;
    end
  end

  // Packed word and index registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o      = word_q;
  assign idx_o       = idx_q;
  assign word_full_o = accept_i && (idx_q == 3'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/wb_loader.sv
// Wishbone master that writes a packed byte stream to consecutive words.
// Define WB_LOADER_READBACK_EN to add wb_data_i and a read-verify step.
module wb_loader
  import loader_pkg::*;
#(
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                   TIMEOUT   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic                 finish_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic [WB_ADDR_W-1:0] wb_addr_o,
  output logic [WB_DATA_W-1:0] wb_data_o,
`ifdef WB_LOADER_READBACK_EN
  input  logic [WB_DATA_W-1:0] wb_data_i,
`endif
  output logic                 wb_cyc_o,
  output logic                 wb_strobe_o,
  output logic                 wb_we_o,
  input  logic                 wb_ack_i,
  output logic                 cpu_hold_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [15:0]          word_count_o
);

  loader_state_t        state_q, state_d;
  logic [WB_ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 hold_q, hold_d;
  logic                 final_q, final_d;

  logic                 pk_clear, pk_flush, pk_full;
  logic [2:0]           pk_idx;
  logic [WB_DATA_W-1:0] pk_word;
  logic                 accept, ack, tmo_exp, fin;

  byte_packer u_packer (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear_i     (pk_clear),
    .flush_i     (pk_flush),
    .accept_i    (accept),
    .byte_i      (byte_i),
    .word_o      (pk_word),
    .idx_o       (pk_idx),
    .word_full_o (pk_full)
  );

  assign byte_ready_o = (state_q == COLLECT);
  assign accept       = byte_valid_i && byte_ready_o;
`ifdef WB_LOADER_READBACK_EN
  assign wb_cyc_o     = (state_q == WRITE) || (state_q == VERIFY);
`else
  assign wb_cyc_o     = (state_q == WRITE);
`endif
  assign wb_strobe_o  = wb_cyc_o;
  assign wb_we_o      = (state_q == WRITE);
  assign wb_addr_o    = wb_cyc_o ? addr_q : '0;
  assign wb_data_o    = wb_cyc_o ? pk_word : '0;
  assign ack          = wb_ack_i && wb_strobe_o;
  assign tmo_exp      = (tmo_q == TIMEOUT_W'(TIMEOUT - 1));
  assign fin          = final_q || finish_i;
  assign cpu_hold_o   = hold_q;
  assign busy_o       = (state_q != IDLE);
  assign err_o        = err_q;
  assign word_count_o = cnt_q;

  // Next-state, bus handshake, timeout and counters
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    hold_d   = hold_q;
    final_d  = final_q;
    pk_clear = 1'b0;
    pk_flush = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = COLLECT;
          hold_d   = 1'b1;
          err_d    = 1'b0;
          cnt_d    = '0;
          addr_d   = BASE_ADDR;
          final_d  = 1'b0;
          pk_clear = 1'b1;
        end
      end
      COLLECT: begin
        if (start_i) begin
          addr_d   = BASE_ADDR;
          final_d  = 1'b0;
          pk_clear = 1'b1;
        end else if (pk_full) begin
          state_d = WRITE;
          tmo_d   = '0;
          final_d = finish_i;
        end else if (finish_i) begin
          if (pk_idx == 3'd0 && !accept) state_d = DONE;
          else state_d = FLUSH;
        end
      end
      FLUSH: begin
        pk_flush = 1'b1;
        final_d  = 1'b1;
        tmo_d    = '0;
        state_d  = WRITE;
      end
      WRITE: begin
        final_d = fin;
        if (ack) begin
`ifdef WB_LOADER_READBACK_EN
          state_d = VERIFY;
          tmo_d   = '0;
`else
          addr_d   = addr_q + 32'd4;
          cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          pk_clear = 1'b1;
          state_d  = fin ? DONE : COLLECT;
`endif
        end else if (tmo_exp) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`ifdef WB_LOADER_READBACK_EN
      VERIFY: begin
        final_d = fin;
        if (ack) begin
          if (wb_data_i != pk_word) err_d = 1'b1;
          addr_d   = addr_q + 32'd4;
          cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          pk_clear = 1'b1;
          state_d  = fin ? DONE : COLLECT;
        end else if (tmo_exp) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`endif
      DONE: begin
        hold_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      final_q <= final_d;
    end
  end

endmodule
